lzc_norm_seq: RTL and testbench

Iterative leading-zero-count and normalization sequencer for the floating-point add/sub path. Accepts a WIDTH-bit post-subtraction mantissa and time-multiplexes a single 8-bit leading-zero counter across its bytes, MSB byte first. Accumulates the leading-zero count, then left-shifts the mantissa so its MSB is 1. Trades one shared 8-bit counter for multi-cycle latency, and sits between the mantissa adder and the exponent-adjust/rounding stage.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/lzc_norm_seq_if.sv | 27 ++
 rtl/lzc_norm_seq_lzc8.sv | 18 +
 rtl/lzc_norm_seq.sv | 138 +++++++++++++
 tb/tb_lzc_norm_seq.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared floating-point path definitions: sequencer state encoding, the LZC
// byte width and the count-width helper.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } lzc_seq_state_t;

  localparam int LZC_BYTE = 8;

  // A count must represent every value 0..width inclusive, hence width+1.
  function automatic int lzc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lzc_norm_seq_if.sv
// Operand/result handshake bundle for lzc_norm_seq. The master side drives
// operands and accepts results; the slave side is the sequencer.
interface lzc_norm_seq_if #(
  parameter int WIDTH = 32
);
  localparam int CW = fpu_pkg::lzc_cw(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [CW-1:0]    out_lzc;
  logic             out_zero;

  modport master (
    output in_valid, in_mant, out_ready,
    input  in_ready, out_valid, out_mant, out_lzc, out_zero
  );

  modport slave (
    input  in_valid, in_mant, out_ready,
    output in_ready, out_valid, out_mant, out_lzc, out_zero
  );

endinterface

// File: rtl/lzc_norm_seq_lzc8.sv
// Team 8-bit leading-zero counter: z is the number of leading zeros of a
// nonzero byte, v flags an all-zero byte (z is then don't-care, driven 0).
module LZC_8_bit (
  input  logic [7:0] data,
  output logic [2:0] z,
  output logic       v
);

  // The highest set bit is visited last, so it decides the count.
  always_comb begin
    z = '0;
    v = (data == 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (data[i]) z = 3'(7 - i);
    end
  end

endmodule

// File: rtl/lzc_norm_seq.sv
// Iterative leading-zero count and normalize: one shared 8-bit LZC walks the
// mantissa MSB byte first, then a single barrel shift normalizes the result.
// Optional LZC_SEQ_BYPASS_EN: operands with MSB already set skip straight to DONE.
module lzc_norm_seq
  import fpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  lzc_norm_seq_if.slave bus
);

  localparam int NBYTES = WIDTH / LZC_BYTE;
  localparam int CW     = lzc_cw(WIDTH);
  localparam int BW     = $clog2(NBYTES);

  lzc_seq_state_t   state_q, state_d;
  logic [WIDTH-1:0] mant_q, mant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    byte_idx_q, byte_idx_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] out_mant_q, out_mant_d;
  logic [CW-1:0]    out_lzc_q, out_lzc_d;
  logic             out_zero_q, out_zero_d;
  logic             out_valid_q, out_valid_d;

  logic [7:0] cur_byte;
  logic [2:0] lzc_z;
  logic       lzc_v;
  logic       bypass_hit;

  assign cur_byte = mant_q[{byte_idx_q, 3'b000} +: LZC_BYTE];

  LZC_8_bit u_lzc8 (
    .data (cur_byte),
    .z    (lzc_z),
    .v    (lzc_v)
  );

`ifdef LZC_SEQ_BYPASS_EN
  assign bypass_hit = bus.in_mant[WIDTH-1];
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    cnt_d       = cnt_q;
    byte_idx_d  = byte_idx_q;
    zero_d      = zero_q;
    out_mant_d  = out_mant_q;
    out_lzc_d   = out_lzc_q;
    out_zero_d  = out_zero_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bypass_hit) begin
            out_mant_d  = bus.in_mant;
            out_lzc_d   = '0;
            out_zero_d  = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            mant_d     = bus.in_mant;
            cnt_d      = '0;
            zero_d     = 1'b0;
            byte_idx_d = BW'(NBYTES - 1);
            state_d    = SCAN;
          end
        end
      end
      SCAN: begin
        if (lzc_v) begin
          cnt_d = cnt_q + CW'(LZC_BYTE);
          if (byte_idx_q == '0) begin
            zero_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            byte_idx_d = byte_idx_q - BW'(1);
          end
        end else begin
          cnt_d   = cnt_q + CW'(lzc_z);
          state_d = SHIFT;
        end
      end
      // A count of WIDTH shifts everything out, which yields the all-zero result.
      SHIFT: begin
        out_mant_d  = mant_q << cnt_q;
        out_lzc_d   = cnt_q;
        out_zero_d  = zero_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      cnt_q       <= '0;
      byte_idx_q  <= '0;
      zero_q      <= 1'b0;
      out_mant_q  <= '0;
      out_lzc_q   <= '0;
      out_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      cnt_q       <= cnt_d;
      byte_idx_q  <= byte_idx_d;
      zero_q      <= zero_d;
      out_mant_q  <= out_mant_d;
      out_lzc_q   <= out_lzc_d;
      out_zero_q  <= out_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_mant  = out_mant_q;
  assign bus.out_lzc   = out_lzc_q;
  assign bus.out_zero  = out_zero_q;

endmodule

// File: tb/tb_lzc_norm_seq.sv
// Bench for lzc_norm_seq at WIDTH=32: directed corner operands, backpressure,
// mid-operation reset and randomized operands against a bit-level reference.
module tb_lzc_norm_seq;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  lzc_norm_seq_if #(.WIDTH(WIDTH)) bus ();

  lzc_norm_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: scan bits from the top, stopping at the first one.
  function automatic int ref_lzc(input logic [31:0] m);
    int n;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) break;
      n++;
    end
    return n;
  endfunction

  // Latency in edges: one per byte examined up to the first nonzero byte, plus the shift.
  function automatic int ref_latency(input logic [31:0] m);
    int n;
    n = ref_lzc(m);
`ifdef LZC_SEQ_BYPASS_EN
    if (m[31]) return 1;
`endif
    if (n == 32) return 5;
    return n / 8 + 2;
  endfunction

  task automatic applyStimulus(input logic [31:0] mant, input int stall);
    int          exp_lzc;
    int          exp_lat;
    int          lat;
    int          waited;
    logic [31:0] exp_mant;
    exp_lzc  = ref_lzc(mant);
    exp_lat  = ref_latency(mant);
    exp_mant = mant << exp_lzc;

    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("in_ready_idle", 64'(bus.in_ready), 64'd1);

    @(negedge clk);
    bus.in_mant   = mant;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_mant  = $urandom();

    lat = 0;
    do begin
      checkOutput("busy_in_ready", 64'(bus.in_ready), 64'd0);
      if (lat > 0 || !bus.out_valid) begin
        @(posedge clk); #1;
      end
      lat++;
    end while (!bus.out_valid && lat < 20);
    checkOutput("latency", 64'(lat), 64'(exp_lat));
    checkOutput("out_lzc", 64'(bus.out_lzc), 64'(exp_lzc));
    checkOutput("out_mant", 64'(bus.out_mant), 64'(exp_mant));
    checkOutput("out_zero", 64'(bus.out_zero), 64'(mant == 32'd0));

    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("hold_lzc", 64'(bus.out_lzc), 64'(exp_lzc));
      checkOutput("hold_mant", 64'(bus.out_mant), 64'(exp_mant));
      checkOutput("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;

    @(posedge clk); #1;
    checkOutput("post_hs_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("post_hs_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] r;
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_mant", 64'(bus.out_mant), 64'd0);
    checkOutput("rst_out_lzc", 64'(bus.out_lzc), 64'd0);
    checkOutput("rst_out_zero", 64'(bus.out_zero), 64'd0);
    rst = 1'b0;

    applyStimulus(32'h8000_0000, 0);
    applyStimulus(32'h0001_0000, 0);
    applyStimulus(32'h0000_1234, 0);
    applyStimulus(32'h0000_0000, 0);
    applyStimulus(32'h00FF_0000, 4);
    applyStimulus(32'h0000_0080, 1);

    // Abandon an operand during its second SCAN cycle.
    @(negedge clk);
    bus.in_mant  = 32'h0000_0001;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    applyStimulus(32'h4000_0000, 0);

    for (int k = 0; k < 60; k++) begin
      r = $urandom() >> $urandom_range(0, 32);
      if ($urandom_range(0, 9) == 0) r = 32'd0;
      applyStimulus(r, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
